// File: rtl/key_debounce.sv
// key_debounce
//   Debounces NUM_KEYS active-low push buttons. Each key is synchronized with
//   two flops, then a per-key counter must see DEBOUNCE_CYCLES consecutive
//   samples that differ from the accepted level before the level flips.
//   Press/release pulses are registered and line up with the level change.
//   A sticky press flag per key is held until software clears it.
//
// Ports (top):
//   clk_clk      in   system clock, rising edge
//   reset_reset  in   asynchronous active-low reset
//   key_raw_n    in   [NUM_KEYS] raw key pins, 0 = pressed, asynchronous
//   event_clr    in   [NUM_KEYS] level-sensitive clear of press_event
//   key_level    out  [NUM_KEYS] debounced level, 1 = pressed
//   key_press    out  [NUM_KEYS] one-cycle pulse on accepted press
//   key_release  out  [NUM_KEYS] one-cycle pulse on accepted release
//   press_event  out  [NUM_KEYS] sticky press flag

module key_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_raw_ni,
    input  logic event_clr_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic event_o
);
    localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

    logic        sync1_q, sync2_q;
    logic        level_q, level_d;
    logic        press_q, release_q, event_q;
    logic [19:0] cnt_q, cnt_d;
    logic        differ, accept;

    // Synchronized sample converted to active-high before comparing.
    assign differ = (!sync2_q) != level_q;
    assign accept = differ && (cnt_q == CNT_MAX);

    // Counter only runs while the input disagrees with the accepted level;
    // any agreeing sample restarts it, and acceptance restarts it too so it
    // never passes CNT_MAX.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q ^ accept;
        if (differ && !accept)
            cnt_d = cnt_q + 20'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            sync1_q   <= key_raw_ni;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= accept && !level_q;
            release_q <= accept && level_q;
            // Set from the registered press pulse wins over a same-cycle clear.
            event_q   <= press_q || (event_q && !event_clr_i);
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign event_o   = event_q;
endmodule

module key_debounce #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [NUM_KEYS-1:0] key_raw_n,
    input  logic [NUM_KEYS-1:0] event_clr,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] press_event
);
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
        key_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk_i      (clk_clk),
            .rst_ni     (reset_reset),
            .key_raw_ni (key_raw_n[g]),
            .event_clr_i(event_clr[g]),
            .level_o    (key_level[g]),
            .press_o    (key_press[g]),
            .release_o  (key_release[g]),
            .event_o    (press_event[g])
        );
    end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter: NUM_KEYS, default 4, number of independent push-button channels.
REQ-002 Parameter: DEBOUNCE_CYCLES, default 500000, consecutive stable clock samples required to accept a new key level (10 ms at 50 MHz); legal range 1 to 2^20-1.
REQ-003 Port: clk_clk  input  1  system clock; all flops on rising edge.
REQ-004 Port: reset_reset  input  1  asynchronous active-low reset; assertion is immediate, deassertion is sampled on clk_clk.
REQ-005 Port: key_raw_n  input  NUM_KEYS  raw board KEY pins, active-low (0 = pressed), asynchronous to clk_clk.
REQ-006 Port: key_level  output  NUM_KEYS  debounced level, active-high (1 = pressed); drives the Nios key PIO export.
REQ-007 Port: key_press  output  NUM_KEYS  one-cycle pulse per bit on an accepted 0->1 transition of key_level.
REQ-008 Port: key_release  output  NUM_KEYS  one-cycle pulse per bit on an accepted 1->0 transition of key_level.
REQ-009 Port: press_event  output  NUM_KEYS  sticky per-key flag, set by key_press and held until cleared.
REQ-010 Port: event_clr  input  NUM_KEYS  per-bit synchronous clear of press_event, level-sensitive.

Function
REQ-011 Each key_raw_n bit SHALL pass through a 2-flop synchronizer, with both flops reset to 1 (released).
REQ-012 Each channel SHALL hold a stable state equal to key_level[i] and a 20-bit counter cnt[i].
REQ-013 When the synchronized pressed value (inverted sync output) differs from key_level[i], cnt[i] SHALL increment by 1 each cycle.
REQ-014 When the synchronized pressed value equals key_level[i], cnt[i] SHALL clear to 0 on that cycle; any glitch shorter than DEBOUNCE_CYCLES therefore leaves key_level unchanged.
REQ-015 On the edge where the difference is sampled with cnt[i] == DEBOUNCE_CYCLES-1, key_level[i] SHALL toggle and cnt[i] SHALL clear to 0.
REQ-016 Latency from a clean raw pin change to the key_level change SHALL be exactly DEBOUNCE_CYCLES+2 rising edges.
REQ-017 key_press[i] / key_release[i] SHALL be registered and asserted in the same cycle key_level[i] first shows its new value, for exactly one cycle.
REQ-018 key_press and key_release SHALL never be high together on the same bit.
REQ-019 press_event[i] SHALL be set when key_press[i] is high and cleared when event_clr[i] is high; when both occur in the same cycle, set SHALL win.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several keys SHALL produce simultaneous pulses on every affected bit.
REQ-021 With DEBOUNCE_CYCLES = 1, a change SHALL be accepted on the first differing synchronized sample (latency 3 edges).
REQ-022 cnt[i] SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL not wrap.

Reset
REQ-023 While reset_reset = 0: synchronizer flops = 1, cnt = 0, key_level = 0, key_press = 0, key_release = 0, press_event = 0.
REQ-024 Reset asserted during a debounce count SHALL discard the partial count. After release, a key still held SHALL be accepted DEBOUNCE_CYCLES+2 edges later and SHALL produce one key_press.

Verification (DEBOUNCE_CYCLES = 4)
REQ-025 Clean press: key_raw_n[0] goes 1->0 and holds -> key_level[0] = 1 and key_press[0] = 1 for one cycle on edge 6; press_event[0] = 1 afterwards.
REQ-026 Bounce: key_raw_n[1] toggles low for 3 cycles, high for 1 cycle, then low and holds -> no pulse during the bounce; key_level[1] rises 6 edges after the final falling edge.
REQ-027 Release: with key 2 held and accepted, key_raw_n[2] goes 0->1 -> key_release[2] pulses once on edge 6; key_level[2] = 0; press_event[2] unchanged.
REQ-028 Set/clear collision: event_clr[0] = 1 in the same cycle as key_press[0] -> press_event[0] = 1; event_clr[0] = 1 one cycle later -> press_event[0] = 0.
REQ-029 Simultaneous: key_raw_n = 4'b0000 from all-released -> key_press = 4'b1111 for one cycle on edge 6.
REQ-030 Reset mid-count: reset_reset pulsed low at edge 4 of a press -> all outputs 0 immediately; key held -> key_press pulses 6 edges after reset release.
